// File: rtl/shift_sequencer.sv
// Multicycle sequencer for the RegDesloc shifter: LOAD -> SHIFT -> CAPTURE -> DONE with start/busy/done handshake.
// Optional macro SHIFT_SEQ_ZERO_BYPASS_EN skips SHIFT when the latched amount is zero.
module shift_sequencer #(
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        shift_op,
  input  logic              amt_sel,
  input  logic [4:0]        amt,
  input  logic [DATA_W-1:0] shifter_out,
  output logic [2:0]        shifter_ctrl,
  output logic              m_shifter,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CAPTURE, S_DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic       sel;
    logic [4:0] amt;
  } shift_req_t;

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [2:0] CTRL_HOLD = 3'b000;
  localparam logic [2:0] CTRL_LOAD = 3'b001;

  state_t           state;
  shift_req_t       req;
  logic [CNT_W-1:0] hold_cnt;
  logic             bypass_zero;

  function automatic logic op_legal(input logic [2:0] op);
    return (op >= 3'b010) && (op <= 3'b110);
  endfunction

`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
  assign bypass_zero = (req.amt == 5'd0);
`else
  // Amount is only needed for the zero bypass; keep it latched but unused here.
  logic unused_amt;
  assign unused_amt  = ^req.amt;
  assign bypass_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      req          <= '0;
      hold_cnt     <= '0;
      shifter_ctrl <= CTRL_HOLD;
      m_shifter    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          shifter_ctrl <= CTRL_HOLD;
          m_shifter    <= 1'b0;
          if (start) begin
            req  <= '{op: shift_op, sel: amt_sel, amt: amt};
            busy <= 1'b1;
            if (op_legal(shift_op)) begin
              state        <= S_LOAD;
              shifter_ctrl <= CTRL_LOAD;
              m_shifter    <= amt_sel;
            end else begin
              // Illegal op never touches the shifter; result keeps its old value.
              state        <= S_DONE;
              err          <= 1'b1;
              done         <= 1'b1;
              result_valid <= 1'b1;
              hold_cnt     <= HOLD_LAST;
            end
          end
        end
        S_LOAD: begin
          m_shifter <= req.sel;
          if (bypass_zero) begin
            state        <= S_CAPTURE;
            shifter_ctrl <= CTRL_HOLD;
          end else begin
            state        <= S_SHIFT;
            shifter_ctrl <= req.op;
          end
        end
        S_SHIFT: begin
          m_shifter    <= req.sel;
          state        <= S_CAPTURE;
          shifter_ctrl <= CTRL_HOLD;
        end
        S_CAPTURE: begin
          result       <= shifter_out;
          state        <= S_DONE;
          shifter_ctrl <= CTRL_HOLD;
          m_shifter    <= 1'b0;
          done         <= 1'b1;
          result_valid <= 1'b1;
          hold_cnt     <= HOLD_LAST;
        end
        S_DONE: begin
          if (hold_cnt == '0) begin
            state        <= S_IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          shifter_ctrl <= CTRL_HOLD;
          m_shifter    <= 1'b0;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer with a behavioural RegDesloc model.
// Define SHIFT_SEQ_ZERO_BYPASS_EN for both files to check the bypass build.
module tb_shift_sequencer;
  localparam int DW   = 32;
  localparam int HOLD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    shift_op = '0;
  logic          amt_sel = 1'b0;
  logic [4:0]    amt = '0;
  logic [DW-1:0] shifter_out;
  logic [2:0]    shifter_ctrl;
  logic          m_shifter, busy, done, result_valid, err;
  logic [DW-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sh_reg = '0;
  logic [31:0] load_val = '0;
  logic [4:0]  cur_amt = '0;
  logic [31:0] exp_result = '0;

  shift_sequencer #(.DATA_W(DW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .shift_op(shift_op), .amt_sel(amt_sel),
    .amt(amt), .shifter_out(shifter_out), .shifter_ctrl(shifter_ctrl), .m_shifter(m_shifter),
    .busy(busy), .done(done), .result_valid(result_valid), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] v,
                                            input logic [4:0] a);
    logic [63:0] dbl;
    dbl = {v, v};
    case (op)
      3'b010:  return v << a;
      3'b011:  return v >> a;
      3'b100:  return $signed(v) >>> a;
      3'b101:  begin dbl = dbl >> a; return dbl[31:0];  end
      3'b110:  begin dbl = dbl << a; return dbl[63:32]; end
      default: return v;
    endcase
  endfunction

  // RegDesloc stand-in: reacts to the control code present during each cycle.
  always @(posedge clk) begin
    if (shifter_ctrl == 3'b001)      sh_reg <= load_val;
    else if (shifter_ctrl != 3'b000) sh_reg <= ref_shift(shifter_ctrl, sh_reg, cur_amt);
  end
  assign shifter_out = sh_reg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input bit noisy);
    start = noisy ? 1'($urandom) : 1'b0;
    if (noisy) begin
      shift_op = 3'($urandom);
      amt_sel  = 1'($urandom);
      amt      = 5'($urandom);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic sel, input logic [4:0] a,
                        input logic [31:0] v, input bit noisy);
    bit          legal, got;
    int          k, exp_lat, rv_cnt;
    logic [11:0] seq, exp_seq;
    legal   = (op >= 3'b010) && (op <= 3'b110);
    exp_lat = legal ? 4 : 1;
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
    if (legal && a == 5'd0) exp_lat = 3;
`endif
    if (!legal)            exp_seq = '0;
    else if (exp_lat == 3) exp_seq = {6'b0, 3'b001, 3'b000};
    else                   exp_seq = {3'b0, 3'b001, op, 3'b000};

    load_val = v; cur_amt = a;
    shift_op = op; amt_sel = sel; amt = a; start = 1'b1;
    got = 0; seq = '0; k = 0;
    while (!got && k < 12) begin
      step; k++;
      if (done) got = 1;
      else begin
        seq = {seq[8:0], shifter_ctrl};
        chk("m_shifter_busy", m_shifter, sel);
        chk("busy_mid", busy, 1);
      end
      noise(noisy);
    end
    chk("done_seen", got, 1);
    chk("latency", k, exp_lat);
    chk("ctrl_seq", seq, exp_seq);
    chk("err", err, !legal);
    chk("rv_at_done", result_valid, 1);
    chk("m_shifter_done", m_shifter, 0);
    if (legal) exp_result = ref_shift(op, v, a);
    chk("result", result, exp_result);

    rv_cnt = 1; k = 0;
    while (k < 20) begin
      step; k++;
      if (!result_valid) break;
      rv_cnt++;
      chk("done_pulse", done, 0);
      chk("err_pulse", err, 0);
      noise(noisy);
    end
    start = 1'b0;
    chk("hold_cycles", rv_cnt, HOLD);
    chk("busy_after", busy, 0);
    step;
    chk("no_queue", busy, 0);
    chk("result_kept", result, exp_result);
  endtask

  task automatic reset_mid_op;
    load_val = 32'hDEAD_BEEF; cur_amt = 5'd3;
    shift_op = 3'b011; amt_sel = 1'b1; amt = 5'd3; start = 1'b1;
    step; start = 1'b0;
    step;
    chk("pre_rst_ctrl", shifter_ctrl, 3'b011);
    #2 reset = 1'b0;
    #1;
    chk("rst_ctrl", shifter_ctrl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_msh", m_shifter, 0);
    chk("rst_err", err, 0);
    exp_result = '0;
    step;
    reset = 1'b1;
    step;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [4:0]  a;
    #1 reset = 1'b0;
    step; step;
    chk("reset_ctrl", shifter_ctrl, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rv", result_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_err", err, 0);
    chk("reset_msh", m_shifter, 0);
    reset = 1'b1;
    step;

    run_op(3'b011, 1'b0, 5'd4, 32'h8000_0000, 0);
    chk("srl_value", result, 32'h0800_0000);
    run_op(3'b100, 1'b0, 5'd4, 32'h8000_0000, 0);
    chk("sra_value", result, 32'hF800_0000);
    run_op(3'b111, 1'b1, 5'd4, 32'h1111_1111, 0);
    chk("illegal_keep", result, 32'hF800_0000);
    run_op(3'b101, 1'b1, 5'd7, 32'h0000_00F1, 1);
    run_op(3'b010, 1'b0, 5'd0, 32'h0000_1234, 0);
    chk("zero_amt", result, 32'h0000_1234);
    reset_mid_op;
    run_op(3'b000, 1'b0, 5'd1, 32'h5, 0);
    chk("illegal_after_rst", result, 32'h0);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_op(op, 1'($urandom), a, $urandom, bit'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multicycle FSM that sequences the RegDesloc shifter inside the logic unit.
- Latches a shift request (op, amount source, amount value), drives the shifter's 3-bit control through load and shift phases, and captures the shifter output into a result register.
- Handshakes with the main control unit via start/busy/done, so the UC no longer hand-times shifter control per state.

Parameters:
- DATA_W, 32, width of shifter data and result.
- HOLD_CYCLES, 1, cycles result_valid stays high in DONE (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- shift_op  input  3  RegDesloc code: 010 sll, 011 srl, 100 sra, 101 ror, 110 rol.
- amt_sel  input  1  0 = amount from SHAMT, 1 = amount from register (drives mux_shifter).
- amt  input  5  effective shift amount (post-mux), used only for zero detect.
- shifter_out  input  DATA_W  RegDesloc output.
- shifter_ctrl  output  3  RegDesloc control: 000 hold, 001 load, others per shift_op.
- m_shifter  output  1  mux_shifter select; equals latched amt_sel while busy.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse on entry to DONE.
- result_valid  output  1  high while in DONE.
- result  output  DATA_W  captured shifter result.
- err  output  1  one-cycle pulse on illegal shift_op.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; shifter_ctrl=000, m_shifter=0, busy=0, done=0, result_valid=0, err=0, result=0, latched op/sel/amt=0.
- States: IDLE, LOAD, SHIFT, CAPTURE, DONE.
- IDLE: shifter_ctrl=000. On start=1, latch shift_op, amt_sel and amt, then go to LOAD. If shift_op ∈ {000, 001, 111}: pulse err the next cycle, leave result unchanged, go straight to DONE.
- LOAD: shifter_ctrl=001 for one cycle (RegDesloc loads ALUSrcB); go to SHIFT.
- SHIFT: shifter_ctrl=latched op for one cycle; go to CAPTURE.
- CAPTURE: shifter_ctrl=000; result <= shifter_out at end of cycle; go to DONE.
- DONE: result_valid=1, with done pulsed on the first cycle only. Remain HOLD_CYCLES cycles, then go to IDLE.
- Latency, start sampled to done: 4 cycles (LOAD, SHIFT, CAPTURE, DONE entry).
- Inputs:
  - start while busy is ignored and never queued.
  - Latched op/sel/amt are stable for the whole operation regardless of input changes.
  - m_shifter holds the latched amt_sel from LOAD through CAPTURE; 0 in IDLE and DONE.
- Amount 0: performs the shift normally (result equals the loaded value).
- start asserted on the same cycle DONE exits to IDLE: not accepted; start must be seen in IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No done, no err. result is cleared.
- All outputs are registered; no combinational path from start to shifter_ctrl.

Optional Feature:
- Macro: SHIFT_SEQ_ZERO_BYPASS_EN.
- Defined: when the latched amt==0 and op is legal, SHIFT is skipped (LOAD→CAPTURE) and latency becomes 3 cycles. shifter_ctrl never emits a shift code for that request.
- Undefined: the SHIFT state is always visited; latency is always 4.

Test Plan:
- Reset, then start with op=011, amt_sel=0, amt=4, shifter model loaded with 0x80000000 → shifter_ctrl sequence 001, 011, 000; done at cycle 4; result=0x08000000.
- op=100, amt=4, value 0x80000000 → result=0xF8000000, result_valid for exactly HOLD_CYCLES cycles, busy low afterwards.
- op=111 → err pulse one cycle, no 001 ever driven on shifter_ctrl, done pulses, result keeps previous 0xF8000000.
- start re-pulsed during SHIFT with op=010 → ignored; first op completes; next request only accepted after return to IDLE.
- reset driven low during SHIFT → asynchronous reset: same cycle shifter_ctrl=000, busy=0, result=0, no done pulse.
- op=010, amt=0, value 0x1234 → result=0x1234. With SHIFT_SEQ_ZERO_BYPASS_EN, done arrives at cycle 3 and code 010 is never driven; without the macro, done arrives at cycle 4.
